pipe_wb_arb: RTL and testbench
==============================

PIPE_WB_ARB -- requirements
Module: pipe_wb_arb

Interface
REQ-001 SHALL take parameter NUM_CH, default 2, the number of writeback source channels (1..8).
REQ-002 SHALL take parameter DEPTH, default 2, per-channel FIFO entries (power of two, >=2).
REQ-003 SHALL take parameter XLEN, default 32, the writeback data width.
REQ-004 SHALL have port clk_i  input  1  clock; one clock only, all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port ch_valid_i  input  NUM_CH  per-channel request valid.
REQ-007 SHALL have port ch_ready_o  output  NUM_CH  per-channel accept.
REQ-008 SHALL have port ch_rd_wen_i  input  NUM_CH  per-channel register write enable.
REQ-009 SHALL have port ch_rd_i  input  NUM_CH x 5  per-channel destination register.
REQ-010 SHALL have port ch_wdata_i  input  NUM_CH x XLEN  per-channel result.
REQ-011 SHALL have port flush_i  input  1  discard all buffered and output entries.
REQ-012 SHALL have port rf_ready_i  input  1  regfile accepts the presented write this cycle.
REQ-013 SHALL have port wb_valid_o  output  1  wb_req_o holds a retiring entry.
REQ-014 SHALL have port wb_req_o  output  wb_req_t (rd_wen, rd, rd_wdata)  regfile write request.
REQ-015 SHALL have port retired_cnt_o  output  32  count of retired entries.

Function
REQ-016 SHALL hold one FIFO per channel; ch_ready_o[i] = FIFO i not full, from registered state only (no combinational path from rf_ready_i).
REQ-017 SHALL push entry i on ch_valid_i[i] && ch_ready_o[i]; when full, ready is low even if popping in the same cycle.
REQ-018 SHALL support push and pop of the same FIFO in one cycle (non-full): occupancy unchanged, order preserved.
REQ-019 SHALL keep a single output register; load when !wb_valid_o || rf_ready_i, from the FIFO head selected by arbitration.
REQ-020 SHALL arbitrate round-robin among non-empty FIFOs, starting at pointer rr; after a grant to channel g, rr = (g+1) mod NUM_CH; rr unchanged when nothing is granted.
REQ-021 SHALL give fixed 2-cycle minimum latency: push at edge N, wb_valid_o high from cycle after edge N+1.
REQ-022 SHALL hold wb_valid_o and wb_req_o stable while wb_valid_o && !rf_ready_i.
REQ-023 SHALL drive wb_req_o.rd_wen = wb_valid_o && stored rd_wen && (rd != 0); rd 0 entries still retire.
REQ-024 SHALL increment retired_cnt_o by 1 on each wb_valid_o && rf_ready_i cycle, wrapping at 2^32.
REQ-025 SHALL on flush_i empty all FIFOs and clear wb_valid_o at the next edge; pushes and retire count updates in that cycle are dropped; rr and retired_cnt_o hold.
REQ-026 SHALL sustain one retirement per cycle when rf_ready_i stays high and any FIFO is non-empty.

Reset
REQ-027 SHALL on rst_i clear all FIFO pointers/counts, wb_valid_o=0, rr=0, retired_cnt_o=0; wb_req_o fields read 0; ch_ready_o all 1 the cycle after reset.
REQ-028 SHALL give rst_i priority over flush_i and all pushes; reset mid-transfer discards all in-flight entries.

Structure
REQ-029 SHALL use wb_req_t from liang_pkg; a packed entry type (rd_wen, rd, wdata) and the counter width constant SHALL be added to liang_pkg.
REQ-030 SHALL instantiate sub-module wb_fifo (parametrised DEPTH, entry type) once per channel; arbiter stays inline.

Verification
REQ-031 Single channel 0 push rd=5 wdata=0xDEADBEEF, rf_ready_i=1 -> wb_valid_o 2 cycles later, rd_wen=1, rd=5, retired_cnt_o=1.
REQ-032 Both channels push every cycle, rf_ready_i=1 -> grants alternate 0,1,0,1; each channel's data in push order; no loss.
REQ-033 rf_ready_i=0 for 6 cycles, channel 0 pushes continuously, DEPTH=2 -> ch_ready_o[0] drops after 2 buffered entries; wb_req_o stable; all 3 entries emerge in order on release.
REQ-034 Push rd=0 rd_wen=1 -> wb_valid_o=1, wb_req_o.rd_wen=0, retired_cnt_o increments.
REQ-035 Fill both FIFOs, assert flush_i with simultaneous push -> next cycle wb_valid_o=0, all ch_ready_o=1, no further output, retired_cnt_o unchanged.
REQ-036 Assert rst_i while wb_valid_o=1 and rf_ready_i=0 -> next cycle all outputs at reset values, retired_cnt_o=0.

Source files
------------

// File: rtl/liang_pkg.sv
// Shared types for the writeback arbiter: the regfile request, the buffered
// entry format and the retire counter width.
package liang_pkg;

  localparam int XLEN_W = 32;
  localparam int CNT_W  = 32;

  typedef struct packed {
    logic              rd_wen;
    logic [4:0]        rd;
    logic [XLEN_W-1:0] rd_wdata;
  } wb_req_t;

  typedef struct packed {
    logic              rd_wen;
    logic [4:0]        rd;
    logic [XLEN_W-1:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-channel writeback buffer: power-of-two circular FIFO with a
// combinational head view so the arbiter can pick and pop in one cycle.
module wb_fifo
  import liang_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   flush_i,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   empty_o,
  output logic   full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];

  // Fullness comes from registered count only, so a same-cycle pop never
  // opens room for a push into a full FIFO.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/pipe_wb_arb.sv
// Writeback arbiter: per-channel FIFOs feed a single registered regfile write
// port through a round-robin pick; counts every retired entry.
module pipe_wb_arb
  import liang_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 2,
  parameter int XLEN   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_CH-1:0]      ch_valid_i,
  output logic [NUM_CH-1:0]      ch_ready_o,
  input  logic [NUM_CH-1:0]      ch_rd_wen_i,
  input  logic [NUM_CH*5-1:0]    ch_rd_i,
  input  logic [NUM_CH*XLEN-1:0] ch_wdata_i,
  input  logic                   flush_i,
  input  logic                   rf_ready_i,
  output logic                   wb_valid_o,
  output wb_req_t                wb_req_o,
  output logic [CNT_W-1:0]       retired_cnt_o
);

  localparam int RR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  wb_entry_t         push_entry [NUM_CH];
  wb_entry_t         head       [NUM_CH];
  logic [NUM_CH-1:0] empty, full, push, pop;

  logic              wb_valid_q, wb_valid_d;
  wb_entry_t         entry_q, entry_d;
  logic [RR_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              grant_valid;
  logic [RR_W-1:0]   grant_idx;
  logic              load;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign push_entry[gi] = '{rd_wen: ch_rd_wen_i[gi],
                                rd:     ch_rd_i[gi*5 +: 5],
                                wdata:  XLEN_W'(ch_wdata_i[gi*XLEN +: XLEN])};
      assign push[gi]       = ch_valid_i[gi] && !full[gi];
      assign ch_ready_o[gi] = !full[gi];

      wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (wb_entry_t)
      ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .push_i      (push[gi]),
        .push_data_i (push_entry[gi]),
        .pop_i       (pop[gi]),
        .head_o      (head[gi]),
        .empty_o     (empty[gi]),
        .full_o      (full[gi])
      );
    end
  endgenerate

  // First non-empty FIFO at or after rr, wrapping.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rr_q) + k) % NUM_CH;
      if (!grant_valid && !empty[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = RR_W'(idx);
      end
    end
  end

  assign load = !wb_valid_q || rf_ready_i;

  always_comb begin
    wb_valid_d = wb_valid_q;
    entry_d    = entry_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    pop        = '0;
    if (flush_i) begin
      wb_valid_d = 1'b0;
    end else begin
      if (wb_valid_q && rf_ready_i) cnt_d = cnt_q + 1'b1;
      if (load) begin
        wb_valid_d = grant_valid;
        if (grant_valid) begin
          entry_d        = head[grant_idx];
          pop[grant_idx] = 1'b1;
          rr_d = (grant_idx == RR_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_q <= 1'b0;
      entry_q    <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      entry_q    <= entry_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Writes to x0 still retire but never reach the register file.
  assign wb_valid_o        = wb_valid_q;
  assign wb_req_o.rd_wen   = wb_valid_q && entry_q.rd_wen && (entry_q.rd != 5'd0);
  assign wb_req_o.rd       = entry_q.rd;
  assign wb_req_o.rd_wdata = entry_q.wdata;
  assign retired_cnt_o     = cnt_q;

endmodule

// File: tb/tb_pipe_wb_arb.sv
// Randomised and directed checks of pipe_wb_arb against a queue-based model.
module tb_pipe_wb_arb;
  import liang_pkg::*;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 2;
  localparam int XLEN   = 32;

  logic                   clk;
  logic                   rst_i;
  logic [NUM_CH-1:0]      ch_valid_i;
  logic [NUM_CH-1:0]      ch_ready_o;
  logic [NUM_CH-1:0]      ch_rd_wen_i;
  logic [NUM_CH*5-1:0]    ch_rd_i;
  logic [NUM_CH*XLEN-1:0] ch_wdata_i;
  logic                   flush_i;
  logic                   rf_ready_i;
  logic                   wb_valid_o;
  wb_req_t                wb_req_o;
  logic [31:0]            retired_cnt_o;

  int tests = 0;
  int fails = 0;

  // Model state: one queue per channel, output slot, pointer, counter.
  logic [37:0] mq [NUM_CH][$];
  bit          m_v;
  logic [37:0] m_e;
  int          m_rr;
  logic [31:0] m_cnt;

  pipe_wb_arb #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .ch_valid_i    (ch_valid_i),
    .ch_ready_o    (ch_ready_o),
    .ch_rd_wen_i   (ch_rd_wen_i),
    .ch_rd_i       (ch_rd_i),
    .ch_wdata_i    (ch_wdata_i),
    .flush_i       (flush_i),
    .rf_ready_i    (rf_ready_i),
    .wb_valid_o    (wb_valid_o),
    .wb_req_o      (wb_req_o),
    .retired_cnt_o (retired_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [72:0] obs_vec();
    return {wb_valid_o, wb_req_o.rd_wen, ch_ready_o, retired_cnt_o,
            wb_valid_o ? {wb_req_o.rd, wb_req_o.rd_wdata} : 37'd0};
  endfunction

  function automatic logic [72:0] exp_vec();
    logic [NUM_CH-1:0] rdy;
    for (int i = 0; i < NUM_CH; i++) rdy[i] = (mq[i].size() < DEPTH);
    return {m_v, m_v && m_e[37] && (m_e[36:32] != 5'd0), rdy, m_cnt,
            m_v ? m_e[36:0] : 37'd0};
  endfunction

  // Advance the model by one clock using the current inputs, then clock the DUT.
  task automatic step();
    bit ready_pre [NUM_CH];
    int g;
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) mq[i].delete();
      m_v = 0; m_e = '0; m_rr = 0; m_cnt = '0;
    end else if (flush_i) begin
      for (int i = 0; i < NUM_CH; i++) mq[i].delete();
      m_v = 0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) ready_pre[i] = (mq[i].size() < DEPTH);
      if (m_v && rf_ready_i) begin
        m_cnt = m_cnt + 1;
        $display("[TB] t=%0t retire rd=%0d data=%h", $time, m_e[36:32], m_e[31:0]);
      end
      if (!m_v || rf_ready_i) begin
        g = -1;
        for (int k = 0; k < NUM_CH; k++)
          if (g < 0 && mq[(m_rr + k) % NUM_CH].size() > 0) g = (m_rr + k) % NUM_CH;
        if (g >= 0) begin
          m_e = mq[g].pop_front(); m_v = 1; m_rr = (g + 1) % NUM_CH;
        end else m_v = 0;
      end
      for (int i = 0; i < NUM_CH; i++)
        if (ch_valid_i[i] && ready_pre[i])
          mq[i].push_back({ch_rd_wen_i[i], ch_rd_i[i*5 +: 5], ch_wdata_i[i*32 +: 32]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ch_valid_i = '0; ch_rd_wen_i = '0; ch_rd_i = '0; ch_wdata_i = '0;
    flush_i = 0; rst_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); rst_i = 1; rf_ready_i = 1;
    step(); step();
    rst_i = 0;
    tests++;
    if (wb_valid_o !== 1'b0 || wb_req_o !== '0 || retired_cnt_o !== 32'd0 || ch_ready_o !== 2'b11) begin
      fails++;
      $display("FAIL reset got v=%b req=%h cnt=%0d rdy=%b exp v=0 req=0 cnt=0 rdy=11",
               wb_valid_o, wb_req_o, retired_cnt_o, ch_ready_o);
    end
  endtask

  task automatic test_single();
    test_reset();
    ch_valid_i = 2'b01; ch_rd_wen_i = 2'b01; ch_rd_i = 10'd5; ch_wdata_i = {32'd0, 32'hDEADBEEF};
    for (int c = 0; c < 4; c++) begin
      step();
      if (c == 0) idle_inputs();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL single c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (c == 1) begin
        tests++;
        if (wb_valid_o !== 1'b1 || wb_req_o !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
          fails++; $display("FAIL single_latency got v=%b req=%h exp v=1 req=%h",
                            wb_valid_o, wb_req_o, {1'b1, 5'd5, 32'hDEADBEEF});
        end
      end
      if (c == 2) begin
        tests++;
        if (retired_cnt_o !== 32'd1) begin
          fails++; $display("FAIL single_cnt got=%0d exp=1", retired_cnt_o);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    test_reset();
    rf_ready_i = 1;
    for (int c = 0; c < 16; c++) begin
      if (c < 10) begin
        ch_valid_i = 2'b11; ch_rd_wen_i = 2'b11;
        ch_rd_i = {5'(c + 1), 5'(c + 11)};
        ch_wdata_i = {32'h1000_0000 + 32'(c), 32'h0000_0000 + 32'(c)};
      end else idle_inputs();
      step();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL back_to_back c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_backpressure();
    wb_req_t held;
    test_reset();
    rf_ready_i = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 6) begin
        ch_valid_i = 2'b01; ch_rd_wen_i = 2'b01; ch_rd_i = 10'(c + 3);
        ch_wdata_i = {32'd0, 32'hA000_0000 + 32'(c)};
      end else begin
        idle_inputs(); rf_ready_i = 1;
      end
      step();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL backpressure c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (c == 1) held = wb_req_o;
      if (c == 5) begin
        tests++;
        if (ch_ready_o[0] !== 1'b0 || wb_req_o !== held || wb_valid_o !== 1'b1) begin
          fails++; $display("FAIL backpressure_hold got rdy0=%b req=%h exp rdy0=0 req=%h",
                            ch_ready_o[0], wb_req_o, held);
        end
      end
    end
  endtask

  task automatic test_rd_zero();
    test_reset();
    ch_valid_i = 2'b10; ch_rd_wen_i = 2'b10; ch_rd_i = 10'd0; ch_wdata_i = {32'h1234_5678, 32'd0};
    for (int c = 0; c < 3; c++) begin
      step();
      if (c == 0) idle_inputs();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL rd_zero c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
    tests++;
    if (retired_cnt_o !== 32'd1) begin
      fails++; $display("FAIL rd_zero_cnt got=%0d exp=1", retired_cnt_o);
    end
  endtask

  task automatic test_flush();
    logic [31:0] cnt_before;
    test_reset();
    rf_ready_i = 0;
    for (int c = 0; c < 4; c++) begin
      ch_valid_i = 2'b11; ch_rd_wen_i = 2'b11; ch_rd_i = {5'd9, 5'd7};
      ch_wdata_i = {32'hB000_0000 + 32'(c), 32'hC000_0000 + 32'(c)};
      step();
    end
    cnt_before = retired_cnt_o;
    flush_i = 1; rf_ready_i = 1;
    step();
    tests++;
    if (wb_valid_o !== 1'b0 || ch_ready_o !== 2'b11 || retired_cnt_o !== cnt_before) begin
      fails++; $display("FAIL flush got v=%b rdy=%b cnt=%0d exp v=0 rdy=11 cnt=%0d",
                        wb_valid_o, ch_ready_o, retired_cnt_o, cnt_before);
    end
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if (wb_valid_o !== 1'b0 || obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL flush_after c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    test_reset();
    rf_ready_i = 1;
    ch_valid_i = 2'b11; ch_rd_wen_i = 2'b11; ch_rd_i = {5'd4, 5'd6};
    ch_wdata_i = {32'h5555_AAAA, 32'h0F0F_0F0F};
    step(); step(); step();
    rf_ready_i = 0;
    step();
    rst_i = 1;
    step();
    rst_i = 0; idle_inputs();
    tests++;
    if (wb_valid_o !== 1'b0 || wb_req_o !== '0 || retired_cnt_o !== 32'd0 || ch_ready_o !== 2'b11) begin
      fails++; $display("FAIL reset_mid got v=%b req=%h cnt=%0d rdy=%b exp v=0 req=0 cnt=0 rdy=11",
                        wb_valid_o, wb_req_o, retired_cnt_o, ch_ready_o);
    end
    step(); step();
    tests++;
    if (wb_valid_o !== 1'b0) begin
      fails++; $display("FAIL reset_mid_drain got v=%b exp v=0", wb_valid_o);
    end
  endtask

  task automatic test_random();
    test_reset();
    for (int c = 0; c < 400; c++) begin
      ch_valid_i  = NUM_CH'($urandom);
      ch_rd_wen_i = NUM_CH'($urandom);
      ch_rd_i     = (NUM_CH*5)'($urandom);
      ch_wdata_i  = {$urandom, $urandom};
      rf_ready_i  = ($urandom_range(0, 9) < 7);
      flush_i     = ($urandom_range(0, 49) == 0);
      rst_i       = ($urandom_range(0, 99) == 0);
      step();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL random c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_i = 1; rf_ready_i = 0;
    m_v = 0; m_e = '0; m_rr = 0; m_cnt = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_rd_zero();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
